// File: rtl/mcu_spi_arbiter_if.sv
// Signal bundle between the MCU SPI link arbiter and its two requesters.
// Requesters drive the master side; the arbiter implements the slave side.
interface mcu_spi_arbiter_if;
   logic       ReqRTC;
   logic       ReqHost;
   logic       GntRTC;
   logic       GntHost;
   logic       RTCnSel;
   logic       RTCDo;
   logic       RTCClkRun;
   logic       RTCClkStretch;
   logic       HostnSel;
   logic       HostDo;
   logic       HostClkRun;
   logic       nMCUSel;
   logic       SPIDo;
   logic       SPIClkRunning;
   logic       SPIClkStretch;
   logic [1:0] Owner;
   logic       Timeout;
   logic       TimeoutClr;

   modport master (
      output ReqRTC, ReqHost, RTCnSel, RTCDo, RTCClkRun, RTCClkStretch,
      output HostnSel, HostDo, HostClkRun, TimeoutClr,
      input  GntRTC, GntHost, nMCUSel, SPIDo, SPIClkRunning, SPIClkStretch,
      input  Owner, Timeout
   );

   modport slave (
      input  ReqRTC, ReqHost, RTCnSel, RTCDo, RTCClkRun, RTCClkStretch,
      input  HostnSel, HostDo, HostClkRun, TimeoutClr,
      output GntRTC, GntHost, nMCUSel, SPIDo, SPIClkRunning, SPIClkStretch,
      output Owner, Timeout
   );
endinterface

// File: rtl/mcu_spi_arbiter.sv
// Round-robin arbiter sharing the MCU SPI link between the RTC engine and the host.
// Optional idle-clock grant revocation is enabled with `define MCU_SPI_TIMEOUT_EN.
module mcu_spi_arbiter #(
   parameter int GUARD_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic              SClk,
   input  logic              nReset,
   mcu_spi_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      OWN_RTC  = 2'b01,
      OWN_HOST = 2'b10,
      GUARD    = 2'b11
   } state_t;

   localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES - 1);

   state_t     state_reg, state_next;
   logic       last_host_reg, last_host_next;
   logic       sel_low_reg, sel_low_next;
   logic [3:0] guard_cnt_reg, guard_cnt_next;
   logic       own_nsel, own_req;
   logic       tmo_hit;

   assign own_nsel = (state_reg == OWN_RTC) ? bus.RTCnSel : bus.HostnSel;
   assign own_req  = (state_reg == OWN_RTC) ? bus.ReqRTC  : bus.ReqHost;

   always_ff @(posedge SClk or negedge nReset) begin
      if (!nReset) begin
         state_reg     <= IDLE;
         last_host_reg <= 1'b1;
         sel_low_reg   <= 1'b0;
         guard_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         last_host_reg <= last_host_next;
         sel_low_reg   <= sel_low_next;
         guard_cnt_reg <= guard_cnt_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      last_host_next = last_host_reg;
      sel_low_next   = sel_low_reg;
      guard_cnt_next = guard_cnt_reg;
      case (state_reg)
         IDLE: begin
            sel_low_next = 1'b0;
            // On contention the requester that did not own last wins
            if (bus.ReqRTC && (!bus.ReqHost || last_host_reg)) begin
               state_next     = OWN_RTC;
               last_host_next = 1'b0;
            end else if (bus.ReqHost) begin
               state_next     = OWN_HOST;
               last_host_next = 1'b1;
            end
         end
         OWN_RTC, OWN_HOST: begin
            if (!own_nsel) sel_low_next = 1'b1;
            // Ownership ends on a completed chip-select frame or on an idle release
            if (tmo_hit || (own_nsel && (sel_low_reg || !own_req))) begin
               state_next     = GUARD;
               guard_cnt_next = GUARD_LOAD;
            end
         end
         GUARD: begin
            if (guard_cnt_reg == 4'd0) state_next = IDLE;
            else guard_cnt_next = guard_cnt_reg - 4'd1;
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.GntRTC        = (state_reg == OWN_RTC);
   assign bus.GntHost       = (state_reg == OWN_HOST);
   assign bus.Owner         = state_reg;
   assign bus.nMCUSel       = (state_reg == OWN_RTC)  ? bus.RTCnSel :
                              (state_reg == OWN_HOST) ? bus.HostnSel : 1'b1;
   assign bus.SPIDo         = (state_reg == OWN_RTC)  ? bus.RTCDo :
                              (state_reg == OWN_HOST) ? bus.HostDo : 1'b1;
   assign bus.SPIClkRunning = (state_reg == OWN_RTC)  ? bus.RTCClkRun :
                              (state_reg == OWN_HOST) ? bus.HostClkRun : 1'b0;
   assign bus.SPIClkStretch = (state_reg == OWN_RTC)  ? bus.RTCClkStretch : 1'b0;

`ifdef MCU_SPI_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic          own, own_clkrun;
   logic [TW-1:0] tmo_cnt_reg;
   logic          timeout_reg;

   assign own        = (state_reg == OWN_RTC) || (state_reg == OWN_HOST);
   assign own_clkrun = (state_reg == OWN_RTC) ? bus.RTCClkRun : bus.HostClkRun;
   assign tmo_hit    = own && !own_clkrun && (tmo_cnt_reg == TMO_LAST);

   always_ff @(posedge SClk or negedge nReset) begin
      if (!nReset) begin
         tmo_cnt_reg <= '0;
         timeout_reg <= 1'b0;
      end else begin
         if (own && !own_clkrun && (state_next == state_reg))
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
         else
            tmo_cnt_reg <= '0;
         // A fresh timeout takes precedence over a simultaneous clear
         if (tmo_hit)             timeout_reg <= 1'b1;
         else if (bus.TimeoutClr) timeout_reg <= 1'b0;
      end
   end

   assign bus.Timeout = timeout_reg;
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   logic unused_timeout_clr;

   assign unused_timeout_clr = bus.TimeoutClr;
   assign tmo_hit            = 1'b0;
   assign bus.Timeout        = 1'b0;
`endif
endmodule

// File: doc/mcu_spi_arbiter.md
MCU_SPI_ARBITER -- requirements
Module: mcu_spi_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- GUARD_CYCLES, 2: cycles nMCUSel is held high between ownerships, 1..15.
- TIMEOUT_CYCLES, 4096: idle-clock cycles before a grant is revoked, power of two, 16..65536.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- SClk  in  1  single clock; all logic on posedge.
- nReset  in  1  asynchronous, active-low reset.
- ReqRTC  in  1  RTC engine requests the MCU SPI link.
- ReqHost  in  1  host SPI controller requests the link.
- GntRTC  out  1  RTC engine owns the link.
- GntHost  out  1  host controller owns the link.
- RTCnSel, RTCDo, RTCClkRun, RTCClkStretch  in  1 each  RTC-side chip select, data out, clock-run and clock-stretch.
- HostnSel, HostDo, HostClkRun  in  1 each  host-side chip select, data out and clock-run.
- nMCUSel  out  1  muxed chip select to the MCU.
- SPIDo  out  1  muxed MOSI.
- SPIClkRunning  out  1  muxed clock enable.
- SPIClkStretch  out  1  muxed clock stretch.
- Owner  out  2  00 none, 01 RTC, 10 host, 11 guard.
- Timeout  out  1  sticky timeout flag.
- TimeoutClr  in  1  clears Timeout.
REQ-003 One clock; reset is asynchronous and active-low; the clock port SHALL be SClk and the reset port SHALL be nReset.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, OWN_RTC, OWN_HOST and GUARD. The register Last SHALL hold the last owner.
REQ-005 In IDLE with a single request, the FSM SHALL move to that requester's OWN state on the next edge.
REQ-006 In IDLE with both requests asserted, the FSM SHALL grant the requester that is not Last (round robin).
REQ-007 Gnt SHALL be registered and asserted for exactly the cycles spent in the matching OWN state. Grant latency from request SHALL be 1 cycle.
REQ-008 In an OWN state, nMCUSel, SPIDo, SPIClkRunning and SPIClkStretch SHALL combinationally follow the owner's inputs. The host stretch input SHALL be treated as 0.
REQ-009 Outside OWN states, outputs SHALL be: nMCUSel=1, SPIDo=1, SPIClkRunning=0, SPIClkStretch=0.
REQ-010 The FSM SHALL leave an OWN state for GUARD on whichever occurs first:
- the owner's nSel rises after having been low during this ownership;
- the owner deasserts Req while its nSel is high.
REQ-011 A requester that deasserts Req while its nSel is low SHALL keep ownership until its nSel rises.
REQ-012 GUARD SHALL last exactly GUARD_CYCLES cycles, then return to IDLE. Requests that arrive during GUARD SHALL be evaluated in IDLE.
REQ-013 Minimum request-to-request turnaround SHALL be GUARD_CYCLES+2 cycles.
REQ-014 Owner SHALL reflect the current state: IDLE=00, OWN_RTC=01, OWN_HOST=10, GUARD=11.
REQ-015 A requester SHALL never see Gnt while the other's Gnt is high, and never in the same cycle.

Reset
REQ-016 Asserting nReset SHALL immediately force the following, including mid-transfer:
- state IDLE, Last = host;
- GntRTC=0, GntHost=0, Owner=00, Timeout=0;
- nMCUSel=1, SPIDo=1, SPIClkRunning=0, SPIClkStretch=0.
REQ-017 The first grant after reset with both requests asserted SHALL go to RTC.

Configuration
REQ-018 Macro MCU_SPI_TIMEOUT_EN, when defined:
- A counter SHALL count cycles in an OWN state with the owner's ClkRun low, and clear on ClkRun high or on state entry.
- When the counter reaches TIMEOUT_CYCLES-1, the block SHALL force GUARD on the next edge, set Timeout and drop Gnt.
- Timeout SHALL clear on TimeoutClr. TimeoutClr SHALL lose to a simultaneous new timeout event.
REQ-019 Without MCU_SPI_TIMEOUT_EN, there SHALL be no counter, Timeout SHALL be tied to 0 and TimeoutClr SHALL be ignored.

Verification
REQ-020 Reset, then assert ReqRTC and ReqHost in the same cycle -> GntRTC=1 one cycle later; after RTC's nSel goes low and then high, the next grant is GntHost after exactly 2 guard cycles.
REQ-021 Host owns the link with HostDo=0, HostnSel=0, HostClkRun=1 -> SPIDo=0, nMCUSel=0, SPIClkRunning=1; RTC inputs toggling have no effect on the outputs.
REQ-022 RTC owns the link and drops ReqRTC with RTCnSel low -> GntRTC stays 1 until RTCnSel rises, then Owner goes 11 for 2 cycles, then 00.
REQ-023 Pull nReset low mid-transfer with nMCUSel=0 -> nMCUSel=1 and both Gnt=0 in the same cycle, with no clock edge required.
REQ-024 With MCU_SPI_TIMEOUT_EN and TIMEOUT_CYCLES=16, RTC is granted with RTCClkRun held low -> GntRTC falls after 16 cycles and Timeout=1; pulse TimeoutClr -> Timeout=0.
REQ-025 Assert ReqHost during GUARD -> GntHost rises exactly 1 cycle after Owner returns to 00.
